// File: rtl/frec_ctrl.sv
// Button/strobe-driven frequency selector: debounces up/down buttons, steps a
// 3-bit index into an 8-entry frequency table, and pulses a divider restart.
//
//   state        | meaning
//   IDLE         | waiting for exactly one synchronized button with lock low
//   DEBOUNCE     | counting stable cycles of the latched button
//   APPLY        | one cycle; new idx/frecnum already registered on entry
//   WAIT_RELEASE | waiting for both buttons released (no auto-repeat)
module frec_ctrl #(
   parameter int unsigned DEB_CYCLES = 50000,
   parameter int unsigned RST_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       lock,
   input  logic       sel_load,
   input  logic [2:0] sel_idx,
   output logic [7:0] frecnum,
   output logic [2:0] idx,
   output logic       changed,
   output logic       div_rst
);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      DEBOUNCE     = 2'd1,
      APPLY        = 2'd2,
      WAIT_RELEASE = 2'd3
   } state_t;

   localparam logic [15:0] DEB_LAST = 16'(DEB_CYCLES - 1);
   localparam logic [3:0]  RST_LOAD = 4'(RST_CYCLES - 1);

   state_t      state_q;
   logic        up_meta_q, up_s_q, dn_meta_q, dn_s_q;
   logic        dir_up_q;
   logic [15:0] deb_cnt_q;
   logic [2:0]  idx_q, idx_d;
   logic [7:0]  frecnum_q;
   logic        changed_q;
   logic        div_rst_q;
   logic [3:0]  rst_cnt_q;
   logic        deb_ok;
   logic        deb_done;

   function automatic logic [7:0] freq_lut(input logic [2:0] i);
      case (i)
         3'd0:    freq_lut = 8'd30;
         3'd1:    freq_lut = 8'd50;
         3'd2:    freq_lut = 8'd75;
         3'd3:    freq_lut = 8'd100;
         3'd4:    freq_lut = 8'd125;
         3'd5:    freq_lut = 8'd150;
         3'd6:    freq_lut = 8'd175;
         default: freq_lut = 8'd200;
      endcase
   endfunction

   always_comb begin
      deb_ok = dir_up_q ? (up_s_q && !dn_s_q && !lock)
                        : (dn_s_q && !up_s_q && !lock);
      deb_done = (state_q == DEBOUNCE) && deb_ok && (deb_cnt_q == DEB_LAST);
   end

   // Index is updated on the edge that enters APPLY so frecnum is visible
   // during the APPLY cycle itself.
   always_comb begin
      idx_d = idx_q;
      if (sel_load) begin
         idx_d = sel_idx;
      end else if (deb_done) begin
         if (dir_up_q) idx_d = (idx_q == 3'd7) ? idx_q : idx_q + 3'd1;
         else          idx_d = (idx_q == 3'd0) ? idx_q : idx_q - 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         up_meta_q <= 1'b0;
         up_s_q    <= 1'b0;
         dn_meta_q <= 1'b0;
         dn_s_q    <= 1'b0;
      end else begin
         up_meta_q <= btn_up;
         up_s_q    <= up_meta_q;
         dn_meta_q <= btn_down;
         dn_s_q    <= dn_meta_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         dir_up_q  <= 1'b0;
         deb_cnt_q <= 16'd0;
         idx_q     <= 3'd0;
         frecnum_q <= 8'd30;
         changed_q <= 1'b0;
      end else begin
         idx_q     <= idx_d;
         frecnum_q <= freq_lut(idx_d);
         changed_q <= (idx_d != idx_q);
         if (sel_load) begin
            state_q   <= WAIT_RELEASE;
            deb_cnt_q <= 16'd0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (!lock && (up_s_q ^ dn_s_q)) begin
                     state_q   <= DEBOUNCE;
                     dir_up_q  <= up_s_q;
                     deb_cnt_q <= 16'd0;
                  end
               end
               DEBOUNCE: begin
                  if (!deb_ok)       state_q <= IDLE;
                  else if (deb_done) state_q <= APPLY;
                  else               deb_cnt_q <= deb_cnt_q + 16'd1;
               end
               APPLY: state_q <= WAIT_RELEASE;
               default: begin
                  if (!up_s_q && !dn_s_q) state_q <= IDLE;
               end
            endcase
         end
      end
   end

   // Down-counter for the restart pulse; any new change reloads it.
   always_ff @(posedge clk) begin
      if (!reset) begin
         div_rst_q <= 1'b0;
         rst_cnt_q <= 4'd0;
      end else if (idx_d != idx_q) begin
         div_rst_q <= 1'b1;
         rst_cnt_q <= RST_LOAD;
      end else if (div_rst_q) begin
         if (rst_cnt_q == 4'd0) div_rst_q <= 1'b0;
         else                   rst_cnt_q <= rst_cnt_q - 4'd1;
      end
   end

   assign frecnum = frecnum_q;
   assign idx     = idx_q;
   assign changed = changed_q;
   assign div_rst = div_rst_q;

endmodule
